dual_port_dmem: RTL and testbench



---
 rtl/dm_pkg.sv | 11 +
 rtl/dm_bank.sv | 26 ++
 rtl/dual_port_dmem.sv | 78 +++++++
 tb/tb_dual_port_dmem.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared widths, FSM states and request record for the dual-port data memory.
package dm_pkg;
   localparam int AW = 9;
   localparam int DW = 16;
   typedef enum logic {CLEAR, RUN} dm_state_e;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          write;
   } dm_req_t;
endpackage

// File: rtl/dm_bank.sv
// dm_bank: storage array with two write ports (port 1 wins on equal address) and two async reads.
module dm_bank #(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we0,
   input  logic [AW-1:0] wa0,
   input  logic [DW-1:0] wd0,
   input  logic          we1,
   input  logic [AW-1:0] wa1,
   input  logic [DW-1:0] wd1,
   input  logic [AW-1:0] ra0,
   input  logic [AW-1:0] ra1,
   output logic [DW-1:0] rd0,
   output logic [DW-1:0] rd1
);
   logic [DW-1:0] mem [2**AW];
   // Port 1 is written last so it overrides port 0 on an address clash.
   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end
   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];
endmodule

// File: rtl/dual_port_dmem.sv
// dual_port_dmem: 512x16 dual-port data memory with zero-fill after reset,
// write-first reads, cross-port forwarding and a sticky write-collision flag.
module dual_port_dmem #(
   parameter int AW             = dm_pkg::AW,
   parameter int DW             = dm_pkg::DW,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] p0_DM_maddr,
   input  logic [DW-1:0] p0_DM_wdata,
   input  logic          p0_DM_write_mem,
   output logic [DW-1:0] p0_DM_rdata,
   input  logic [AW-1:0] p1_DM_maddr,
   input  logic [DW-1:0] p1_DM_wdata,
   input  logic          p1_DM_write_mem,
   output logic [DW-1:0] p1_DM_rdata,
   output logic          dm_ready,
   output logic          dm_collision
);
   import dm_pkg::*;
   dm_state_e     state, state_nx;
   dm_req_t       r0, r1;
   logic [AW-2:0] cnt;
   logic          run, wr0, wr1, same;
   logic          bwe0, bwe1;
   logic [AW-1:0] bwa0, bwa1;
   logic [DW-1:0] bwd0, bwd1, brd0, brd1;

   assign r0   = '{addr: p0_DM_maddr, wdata: p0_DM_wdata, write: p0_DM_write_mem};
   assign r1   = '{addr: p1_DM_maddr, wdata: p1_DM_wdata, write: p1_DM_write_mem};
   assign wr0  = run & r0.write;
   assign wr1  = run & r1.write;
   assign same = r0.addr == r1.addr;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= CLEAR;
      else      state <= state_nx;

   always_comb
      state_nx = (state == CLEAR && (!CLEAR_ON_RESET || &cnt)) ? RUN : state;

   // During CLEAR both bank ports zero an even/odd word pair per cycle.
   always_comb begin
      run      = state == RUN;
      dm_ready = run;
      bwe0     = run ? r0.write : CLEAR_ON_RESET;
      bwe1     = run ? r1.write : CLEAR_ON_RESET;
      bwa0     = run ? r0.addr : {cnt, 1'b0};
      bwa1     = run ? r1.addr : {cnt, 1'b1};
      bwd0     = run ? r0.wdata : '0;
      bwd1     = run ? r1.wdata : '0;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst)     cnt <= '0;
      else if (!run) cnt <= cnt + 1'b1;

   dm_bank #(.AW(AW), .DW(DW)) u_bank (
      .clk (clk),
      .we0 (bwe0), .wa0 (bwa0), .wd0 (bwd0),
      .we1 (bwe1), .wa1 (bwa1), .wd1 (bwd1),
      .ra0 (r0.addr), .ra1 (r1.addr),
      .rd0 (brd0), .rd1 (brd1)
   );

   // Each port returns the word as it stands after this cycle's writes.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         p0_DM_rdata  <= '0;
         p1_DM_rdata  <= '0;
         dm_collision <= 1'b0;
      end else if (run) begin
         p0_DM_rdata <= (wr1 && same) ? r1.wdata : wr0 ? r0.wdata : brd0;
         p1_DM_rdata <= wr1 ? r1.wdata : (wr0 && same) ? r0.wdata : brd1;
         if (wr0 && wr1 && same) dm_collision <= 1'b1;
      end
endmodule

// File: tb/tb_dual_port_dmem.sv
// tb_dual_port_dmem: table vectors, hand sequences and randomized traffic against a memory model.
module tb_dual_port_dmem;
   logic        clk = 0;
   logic        rst = 0;
   logic [8:0]  a0 = 0, a1 = 0;
   logic [15:0] d0 = 0, d1 = 0;
   logic        w0 = 0, w1 = 0;
   logic [15:0] q0, q1;
   logic        ready, coll;

   int n_cmp = 0, n_bad = 0;
   logic [15:0] mem_m [512];
   bit coll_m;

   typedef struct {
      bit w0; logic [8:0] a0; logic [15:0] d0;
      bit w1; logic [8:0] a1; logic [15:0] d1;
      logic [15:0] e0, e1; bit ec;
   } vec_t;
   vec_t vt [9];

   dual_port_dmem dut (
      .clk(clk), .rst(rst),
      .p0_DM_maddr(a0), .p0_DM_wdata(d0), .p0_DM_write_mem(w0), .p0_DM_rdata(q0),
      .p1_DM_maddr(a1), .p1_DM_wdata(d1), .p1_DM_write_mem(w1), .p1_DM_rdata(q1),
      .dm_ready(ready), .dm_collision(coll)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input bit iw0, input logic [8:0] ia0, input logic [15:0] id0,
                       input bit iw1, input logic [8:0] ia1, input logic [15:0] id1);
      w0 = iw0; a0 = ia0; d0 = id0; w1 = iw1; a1 = ia1; d1 = id1;
      @(posedge clk);
      #1;
   endtask

   // Model: apply this cycle's writes (port 1 last), then each port sees the resulting word.
   task automatic model(input bit iw0, input logic [8:0] ia0, input logic [15:0] id0,
                        input bit iw1, input logic [8:0] ia1, input logic [15:0] id1,
                        output logic [15:0] e0, output logic [15:0] e1);
      if (iw0) mem_m[ia0] = id0;
      if (iw1) mem_m[ia1] = id1;
      if (iw0 && iw1 && ia0 == ia1) coll_m = 1;
      e0 = mem_m[ia0];
      e1 = mem_m[ia1];
   endtask

   task automatic model_reset();
      foreach (mem_m[i]) mem_m[i] = '0;
      coll_m = 0;
   endtask

   task automatic wait_ready(output int n, output bit zero_ok);
      n = 0;
      zero_ok = 1;
      while (n < 400) begin
         step(1, 9'(n), 16'hFFFF, 1, 9'(n + 7), 16'hA5A5);
         n++;
         if (q0 !== 16'h0 || q1 !== 16'h0) zero_ok = 0;
         if (ready) break;
      end
   endtask

   initial begin
      int n;
      bit zok;
      logic [15:0] e0, e1;
      bit rw0, rw1;
      logic [8:0] ra0, ra1;
      logic [15:0] rd0, rd1;

      vt[0] = '{1, 9'h010, 16'h1234, 0, 9'h011, 16'h0000, 16'h1234, 16'h0000, 0};
      vt[1] = '{0, 9'h0FF, 16'h0000, 0, 9'h010, 16'h0000, 16'h0000, 16'h1234, 0};
      vt[2] = '{1, 9'h020, 16'hBEEF, 0, 9'h020, 16'h0000, 16'hBEEF, 16'hBEEF, 0};
      vt[3] = '{0, 9'h022, 16'h0000, 1, 9'h022, 16'h4321, 16'h4321, 16'h4321, 0};
      vt[4] = '{1, 9'h030, 16'hAAAA, 1, 9'h030, 16'h5555, 16'h5555, 16'h5555, 1};
      vt[5] = '{0, 9'h030, 16'h0000, 0, 9'h1FF, 16'h0000, 16'h5555, 16'h0000, 1};
      vt[6] = '{1, 9'h050, 16'h1111, 1, 9'h051, 16'h2222, 16'h1111, 16'h2222, 1};
      vt[7] = '{0, 9'h051, 16'h0000, 0, 9'h050, 16'h0000, 16'h2222, 16'h1111, 1};
      vt[8] = '{0, 9'h000, 16'h0000, 1, 9'h000, 16'h0F0F, 16'h0F0F, 16'h0F0F, 1};

      repeat (3) step(1, 9'h5, 16'h1, 1, 9'h6, 16'h2);
      chk("rst_q0", q0, 0);
      chk("rst_q1", q1, 0);
      chk("rst_ready", ready, 0);
      chk("rst_coll", coll, 0);

      rst = 1;
      wait_ready(n, zok);
      chk("fill_latency", n, 256);
      chk("clear_rdata_zero", zok, 1);
      model_reset();

      step(0, 9'h000, 0, 0, 9'h0FF, 0);
      chk("fill_000", q0, 0);
      chk("fill_0ff", q1, 0);
      step(0, 9'h1FF, 0, 0, 9'h100, 0);
      chk("fill_1ff", q0, 0);
      chk("fill_100", q1, 0);

      foreach (vt[i]) begin
         step(vt[i].w0, vt[i].a0, vt[i].d0, vt[i].w1, vt[i].a1, vt[i].d1);
         model(vt[i].w0, vt[i].a0, vt[i].d0, vt[i].w1, vt[i].a1, vt[i].d1, e0, e1);
         chk($sformatf("vec%0d_q0", i), q0, vt[i].e0);
         chk($sformatf("vec%0d_q1", i), q1, vt[i].e1);
         chk($sformatf("vec%0d_coll", i), coll, vt[i].ec);
      end

      for (int i = 0; i < 10; i++) begin
         step(0, 9'h030, 0, 0, 9'h031, 0);
         model(0, 9'h030, 0, 0, 9'h031, 0, e0, e1);
         chk($sformatf("coll_sticky%0d", i), coll, 1);
      end
      chk("collided_word", q0, 16'h5555);

      for (int i = 0; i < 300; i++) begin
         rw0 = 1'($urandom_range(0, 1));
         rw1 = 1'($urandom_range(0, 1));
         ra0 = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
         ra1 = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
         rd0 = 16'($urandom);
         rd1 = 16'($urandom);
         step(rw0, ra0, rd0, rw1, ra1, rd1);
         model(rw0, ra0, rd0, rw1, ra1, rd1, e0, e1);
         chk($sformatf("rnd%0d_q0", i), q0, e0);
         chk($sformatf("rnd%0d_q1", i), q1, e1);
         chk($sformatf("rnd%0d_coll", i), coll, coll_m);
      end

      step(1, 9'h040, 16'h7777, 0, 9'h040, 0);
      model(1, 9'h040, 16'h7777, 0, 9'h040, 0, e0, e1);
      chk("pre_rst_q1", q1, 16'h7777);
      rst = 0;
      #1;
      chk("async_coll", coll, 0);
      chk("async_ready", ready, 0);
      chk("async_q1", q1, 0);
      step(0, 0, 0, 0, 0, 0);
      rst = 1;
      repeat (100) step(0, 0, 0, 0, 0, 0);
      chk("mid_fill_ready", ready, 0);
      rst = 0;
      step(0, 0, 0, 0, 0, 0);
      rst = 1;
      wait_ready(n, zok);
      chk("refill_latency", n, 256);
      chk("refill_rdata_zero", zok, 1);
      model_reset();
      step(0, 9'h040, 0, 0, 9'h0C8, 0);
      chk("cleared_040", q0, 0);
      chk("cleared_0c8", q1, 0);
      chk("coll_after_rst", coll, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
